melody_player: RTL

MELODY_PLAYER -- requirements
Module: melody_player

---
 rtl/melody_player_pkg.sv | 39 +++
 rtl/melody_player_if.sv | 15 +
 rtl/melody_rom.sv | 19 +
 rtl/melody_player.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/melody_player_pkg.sv
// Shared types and constants for the melody player: FSM states, ROM entry
// layout and the note-code to buzzer-key lookup.
package melody_player_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  localparam int         ENTRY_W    = 12;
  localparam logic [3:0] REST_CODE  = 4'd0;
  localparam logic [3:0] END_CODE   = 4'd15;
  localparam logic [7:0] KEY_SILENT = 8'hFF;

  // Active-low key codes indexed by note code; the end marker maps to silence.
  localparam logic [7:0] KEY_LUT [16] = '{
    8'hFF,                                            // rest
    8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF,  // low 1..7
    8'h7F,                                            // high 1
    8'h7E, 8'h7D, 8'h7B, 8'h77, 8'h6F, 8'h5F,         // high 2..7
    8'hFF                                             // end marker
  };

  function automatic logic [7:0] code_to_key(input logic [3:0] code);
    return (code == REST_CODE || code == END_CODE) ? KEY_SILENT : KEY_LUT[code];
  endfunction

  // Note length in clk cycles; a zero beat count still plays one beat.
  function automatic logic [31:0] note_cycles(input logic [7:0] beats,
                                              input logic [31:0] beat_cycles);
    logic [7:0] b;
    b = (beats == 8'd0) ? 8'd1 : beats;
    return {24'd0, b} * beat_cycles;
  endfunction

endpackage

// File: rtl/melody_player_if.sv
// Control/status bundle between a host and the melody player.
interface melody_player_if #(
  parameter int AW = 6
);
  logic          start;
  logic          stop;
  logic          loop_en;
  logic [7:0]    key;
  logic          busy;
  logic          done;
  logic [AW-1:0] note_idx;

  modport master (output start, stop, loop_en, input key, busy, done, note_idx);
  modport slave  (input start, stop, loop_en, output key, busy, done, note_idx);
endinterface

// File: rtl/melody_rom.sv
// Melody storage: one 12-bit entry per address ({code, beats}), registered read.
module melody_rom
  import melody_player_pkg::*;
#(
  parameter int                         DEPTH    = 64,
  parameter int                         AW       = $clog2(DEPTH),
  parameter logic [DEPTH*ENTRY_W-1:0]   CONTENTS = {DEPTH{END_CODE, 8'd0}}
) (
  input  logic               clk,
  input  logic [AW-1:0]      addr,
  output logic [ENTRY_W-1:0] data
);

  // Synchronous read: data for addr is valid the cycle after it is presented.
  always_ff @(posedge clk) begin
    data <= CONTENTS[32'(addr)*ENTRY_W +: ENTRY_W];
  end

endmodule

// File: rtl/melody_player.sv
// Melody sequencer: walks the ROM, holds each note's key for its beat count,
// inserts a silent articulation gap, and loops or finishes at the end marker.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | silent, waiting for start
// S_FETCH | ROM entry for addr is on rom_data; decode it this cycle
// S_PLAY  | key held, duration counter running down
// S_GAP   | key forced silent for the articulation gap
// S_DONE  | one-cycle done pulse, then back to idle
module melody_player
  import melody_player_pkg::*;
#(
  parameter int                       BEAT_CYCLES = 3125000,
  parameter int                       GAP_CYCLES  = 250000,
  parameter int                       DEPTH       = 64,
  parameter logic [DEPTH*ENTRY_W-1:0] ROM_TABLE   =
    {{(DEPTH-3){END_CODE, 8'd0}}, 12'h304, 12'h202, 12'h102}
) (
  input  logic           clk,
  input  logic           rst,
  melody_player_if.slave bus
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [31:0]   BEAT_W    = 32'(BEAT_CYCLES);
  localparam logic [31:0]   GAP_W     = 32'(GAP_CYCLES);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH-1);

  state_t        state, state_d, adv_state;
  logic [AW-1:0] addr, addr_d, adv_addr;
  logic [7:0]    key_q, key_d;
  logic [31:0]   cnt, cnt_d;
  logic [11:0]   rom_data;
  logic [3:0]    rom_code;
  logic [7:0]    rom_beats;

  assign rom_code  = rom_data[11:8];
  assign rom_beats = rom_data[7:0];

  // The ROM is addressed with the next address so the entry is already
  // registered on its output during the single FETCH cycle.
  melody_rom #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .CONTENTS(ROM_TABLE)
  ) u_rom (
    .clk (clk),
    .addr(addr_d),
    .data(rom_data)
  );

  // Successor after a finished note: next entry, or end-of-melody handling
  // when the address would wrap past the last ROM entry.
  always_comb begin
    adv_state = S_FETCH;
    adv_addr  = addr + AW'(1);
    if (addr == LAST_ADDR) begin
      adv_addr  = '0;
      adv_state = bus.loop_en ? S_FETCH : S_DONE;
    end
  end

  // Next-state, address, key and counter logic; stop overrides everything.
  always_comb begin
    state_d = state;
    addr_d  = addr;
    key_d   = key_q;
    cnt_d   = cnt;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
          addr_d  = '0;
        end
      end
      S_FETCH: begin
        if (rom_code == END_CODE) begin
          addr_d  = '0;
          state_d = bus.loop_en ? S_FETCH : S_DONE;
        end else begin
          state_d = S_PLAY;
          key_d   = code_to_key(rom_code);
          cnt_d   = note_cycles(rom_beats, BEAT_W) - 32'd1;
        end
      end
      S_PLAY: begin
        if (cnt != 32'd0) begin
          cnt_d = cnt - 32'd1;
        end else begin
          key_d = KEY_SILENT;
          if (GAP_CYCLES == 0) begin
            state_d = adv_state;
            addr_d  = adv_addr;
          end else begin
            state_d = S_GAP;
            cnt_d   = GAP_W - 32'd1;
          end
        end
      end
      S_GAP: begin
        if (cnt != 32'd0) begin
          cnt_d = cnt - 32'd1;
        end else begin
          state_d = adv_state;
          addr_d  = adv_addr;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        key_d   = KEY_SILENT;
      end
    endcase
    if (bus.stop) begin
      state_d = S_IDLE;
      addr_d  = '0;
      key_d   = KEY_SILENT;
      cnt_d   = '0;
    end
  end

  // State, address, key and counter registers; reset silences the key at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      addr  <= '0;
      key_q <= KEY_SILENT;
      cnt   <= '0;
    end else begin
      state <= state_d;
      addr  <= addr_d;
      key_q <= key_d;
      cnt   <= cnt_d;
    end
  end

  assign bus.key      = key_q;
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.note_idx = addr;

endmodule
